// File: rtl/decimals_select.sv
// decimals_select: pushbutton-driven selector for the number of displayed
// decimals. Two raw active-low keys are synchronised, debounced, qualified
// and auto-repeated before driving a saturating 0..MAX_DECIMALS counter.
module decimals_select #(
    parameter int unsigned DEBOUNCE_CYCLES = 500000,
    parameter int unsigned HOLD_CYCLES     = 25000000,
    parameter int unsigned REPEAT_CYCLES   = 10000000,
    parameter int unsigned MAX_DECIMALS    = 5,
    parameter int unsigned RESET_DECIMALS  = 2
) (
    input  logic       clk,
    input  logic       reset_n,
    input  logic       key_up_n,
    input  logic       key_down_n,
    output logic [2:0] decimals,
    output logic       changed
);

    localparam int unsigned DW   = $clog2(DEBOUNCE_CYCLES + 1);
    localparam int unsigned TMAX = (HOLD_CYCLES > REPEAT_CYCLES) ? HOLD_CYCLES : REPEAT_CYCLES;
    localparam int unsigned TW   = $clog2(TMAX + 1);

    localparam logic [DW-1:0] DB_LAST     = DW'(DEBOUNCE_CYCLES - 1);
    localparam logic [TW-1:0] HOLD_LAST   = TW'(HOLD_CYCLES - 1);
    localparam logic [TW-1:0] REPEAT_LAST = TW'(REPEAT_CYCLES - 1);
    localparam logic [2:0]    MAX_VAL     = 3'(MAX_DECIMALS);
    localparam logic [2:0]    RST_VAL     = 3'(RESET_DECIMALS);

    typedef enum logic [1:0] {
        S_IDLE,
        S_HOLD,
        S_REPEAT
    } state_t;

    // Bit 0 = up key, bit 1 = down key; all levels are 1 = pressed.
    logic [1:0]    r_sync1;
    logic [1:0]    r_sync2;
    logic [1:0]    r_deb;
    logic [DW-1:0] r_db_cnt [2];

    state_t        r_state;
    state_t        w_state_nxt;
    logic          r_dir;          // latched direction, 1 = down
    logic          w_dir_nxt;
    logic [TW-1:0] r_timer;
    logic [TW-1:0] w_timer_nxt;
    logic          w_step;
    logic          w_step_dn;

    logic          w_single;
    logic          w_cur_dn;
    logic          w_keep;

    assign w_single = r_deb[0] ^ r_deb[1];
    assign w_cur_dn = r_deb[1];
    assign w_keep   = w_single && (w_cur_dn == r_dir);

    // Two-flop synchroniser with inversion to active-high pressed levels.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_sync1 <= '0;
            r_sync2 <= '0;
        end else begin
            r_sync1 <= ~{key_down_n, key_up_n};
            r_sync2 <= r_sync1;
        end
    end

    // Per-key debouncer: level changes only after a run of disagreeing samples.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_deb <= '0;
            for (int unsigned k = 0; k < 2; k++) begin
                r_db_cnt[k] <= '0;
            end
        end else begin
            for (int unsigned k = 0; k < 2; k++) begin
                if (r_sync2[k] == r_deb[k]) begin
                    r_db_cnt[k] <= '0;
                end else if (r_db_cnt[k] == DB_LAST) begin
                    r_deb[k]    <= r_sync2[k];
                    r_db_cnt[k] <= '0;
                end else begin
                    r_db_cnt[k] <= r_db_cnt[k] + 1'b1;
                end
            end
        end
    end

    // Repeat FSM state, direction and timer registers.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_state <= S_IDLE;
            r_dir   <= 1'b0;
            r_timer <= '0;
        end else begin
            r_state <= w_state_nxt;
            r_dir   <= w_dir_nxt;
            r_timer <= w_timer_nxt;
        end
    end

    // Repeat FSM next-state and step generation.
    always_comb begin
        w_state_nxt = r_state;
        w_dir_nxt   = r_dir;
        w_timer_nxt = r_timer;
        w_step      = 1'b0;
        w_step_dn   = r_dir;
        case (r_state)
            S_IDLE: begin
                if (w_single) begin
                    w_step      = 1'b1;
                    w_step_dn   = w_cur_dn;
                    w_dir_nxt   = w_cur_dn;
                    w_timer_nxt = '0;
                    w_state_nxt = S_HOLD;
                end
            end
            S_HOLD: begin
                if (!w_keep) begin
                    w_timer_nxt = '0;
                    w_state_nxt = S_IDLE;
                end else if (r_timer == HOLD_LAST) begin
                    w_step      = 1'b1;
                    w_timer_nxt = '0;
                    w_state_nxt = S_REPEAT;
                end else begin
                    w_timer_nxt = r_timer + 1'b1;
                end
            end
            S_REPEAT: begin
                if (!w_keep) begin
                    w_timer_nxt = '0;
                    w_state_nxt = S_IDLE;
                end else if (r_timer == REPEAT_LAST) begin
                    w_step      = 1'b1;
                    w_timer_nxt = '0;
                end else begin
                    w_timer_nxt = r_timer + 1'b1;
                end
            end
            default: begin
                w_timer_nxt = '0;
                w_state_nxt = S_IDLE;
            end
        endcase
    end

    // Saturating decimals counter with a one-cycle change pulse.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            decimals <= RST_VAL;
            changed  <= 1'b0;
        end else begin
            changed <= 1'b0;
            if (w_step) begin
                if (w_step_dn && (decimals != 3'd0)) begin
                    decimals <= decimals - 3'd1;
                    changed  <= 1'b1;
                end else if (!w_step_dn && (decimals != MAX_VAL)) begin
                    decimals <= decimals + 3'd1;
                    changed  <= 1'b1;
                end
            end
        end
    end

endmodule
